sd_init_sequencer: RTL and testbench

- Autonomous SDIO card bring-up controller. Drives the command/response interface of the SD host stack (cmd_en/cmd/arg/rsp_long/finished/rsp/error) through the sequence CMD0 → CMD5 probe → CMD5 OCR poll → CMD3 → CMD7.
- Reports RCA, function count and memory-present to the host register block, then releases the command interface to software.
- Sits in the host-clock domain, between the wishbone register file and the stack's command port.

---
 rtl/sd_init_sequencer.sv | 246 ++++++++++++++++++++++++
 tb/tb_sd_init_sequencer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sd_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : sd_init_sequencer
// Brief    : Autonomous SDIO bring-up controller. Walks the card through
//            CMD0, CMD5 probe, CMD5 OCR poll, CMD3 and CMD7, then reports the
//            RCA, function count and memory-present flag to the host.
// Revision : 1.0 - initial release
// ============================================================================
module sd_init_sequencer #(
    parameter logic [23:0] OCR_VOLT    = 24'h300000,
    parameter int          RETRY_MAX   = 100,
    parameter int          GAP_CYCLES  = 1000,
    parameter int          CMD_TIMEOUT = 100000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_start,
    input  logic         i_card_detect,
    input  logic         i_sd_ready,
    output logic         o_busy,
    output logic         o_done,
    output logic         o_fail,
    output logic [3:0]   o_fail_code,
    output logic [15:0]  o_rca,
    output logic [2:0]   o_num_funcs,
    output logic         o_mem_present,
    output logic         o_cmd_en,
    output logic [5:0]   o_cmd,
    output logic [31:0]  o_cmd_arg,
    output logic         o_rsp_long_flag,
    input  logic         i_cmd_finished_en,
    input  logic [127:0] i_rsp,
    input  logic         i_error_flag,
    input  logic [7:0]   i_error
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_RDY = 3'd1,
        S_ISSUE    = 3'd2,
        S_CHECK    = 3'd3,
        S_GAP      = 3'd4,
        S_DONE     = 3'd5,
        S_FAIL     = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        STEP_CMD0  = 3'd0,
        STEP_PROBE = 3'd1,
        STEP_OCR   = 3'd2,
        STEP_CMD3  = 3'd3,
        STEP_CMD7  = 3'd4
    } step_t;

    localparam logic [3:0]  c_FAIL_NOCARD  = 4'd1;
    localparam logic [3:0]  c_FAIL_TIMEOUT = 4'd2;
    localparam logic [3:0]  c_FAIL_STACK   = 4'd3;
    localparam logic [3:0]  c_FAIL_RETRY   = 4'd4;
    localparam logic [3:0]  c_FAIL_VOLT    = 4'd5;
    localparam logic [3:0]  c_FAIL_REMOVED = 4'd6;

    // Terminal counts: each counter starts at 0, so the last value is N-1.
    localparam logic [19:0] c_TMO_LAST     = 20'(CMD_TIMEOUT - 1);
    localparam logic [19:0] c_GAP_LAST     = 20'(GAP_CYCLES - 1);
    localparam logic [7:0]  c_RETRY_MAX    = 8'(RETRY_MAX);

    state_t      r_state;
    step_t       r_step;
    logic [19:0] r_tmo_cnt;
    logic [19:0] r_gap_cnt;
    logic [7:0]  r_retry;
    logic [31:0] r_rsp;
    logic        r_err;

    logic [5:0]  w_cmd_idx;
    logic [31:0] w_cmd_arg;
    logic [7:0]  w_retry_next;

    // Stack-side error code and long-response bits carry no meaning here.
    logic        w_unused_bits;
    assign w_unused_bits   = ^{i_error, i_rsp[127:32]};

    assign o_rsp_long_flag = 1'b0;
    assign w_retry_next    = r_retry + 8'd1;

    // Command index and argument for the step about to be issued.
    always_comb begin
        w_cmd_idx = 6'd0;
        w_cmd_arg = 32'h0;
        case (r_step)
            STEP_CMD0:  begin w_cmd_idx = 6'd0; w_cmd_arg = 32'h0;             end
            STEP_PROBE: begin w_cmd_idx = 6'd5; w_cmd_arg = 32'h0;             end
            STEP_OCR:   begin w_cmd_idx = 6'd5; w_cmd_arg = {8'h00, OCR_VOLT}; end
            STEP_CMD3:  begin w_cmd_idx = 6'd3; w_cmd_arg = 32'h0;             end
            STEP_CMD7:  begin w_cmd_idx = 6'd7; w_cmd_arg = {o_rca, 16'h0};    end
            default:    begin w_cmd_idx = 6'd0; w_cmd_arg = 32'h0;             end
        endcase
    end

    // Bring-up sequencer: state, step, counters and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= S_IDLE;
            r_step        <= STEP_CMD0;
            r_tmo_cnt     <= 20'd0;
            r_gap_cnt     <= 20'd0;
            r_retry       <= 8'd0;
            r_rsp         <= 32'h0;
            r_err         <= 1'b0;
            o_busy        <= 1'b0;
            o_done        <= 1'b0;
            o_fail        <= 1'b0;
            o_fail_code   <= 4'd0;
            o_rca         <= 16'h0;
            o_num_funcs   <= 3'd0;
            o_mem_present <= 1'b0;
            o_cmd_en      <= 1'b0;
            o_cmd         <= 6'd0;
            o_cmd_arg     <= 32'h0;
        end else if (r_state == S_IDLE || r_state == S_DONE || r_state == S_FAIL) begin
            if (i_start) begin
                o_done        <= 1'b0;
                o_rca         <= 16'h0;
                o_num_funcs   <= 3'd0;
                o_mem_present <= 1'b0;
                r_retry       <= 8'd0;
                if (!i_card_detect) begin
                    r_state     <= S_FAIL;
                    o_fail      <= 1'b1;
                    o_fail_code <= c_FAIL_NOCARD;
                end else begin
                    r_state     <= S_WAIT_RDY;
                    r_step      <= STEP_CMD0;
                    o_busy      <= 1'b1;
                    o_fail      <= 1'b0;
                    o_fail_code <= 4'd0;
                end
            end
        end else if (!i_card_detect) begin
            // Removal outranks any completion or timeout in the same cycle.
            r_state     <= S_FAIL;
            o_busy      <= 1'b0;
            o_fail      <= 1'b1;
            o_fail_code <= c_FAIL_REMOVED;
            o_cmd_en    <= 1'b0;
        end else begin
            case (r_state)
                S_WAIT_RDY: begin
                    if (i_sd_ready && !i_cmd_finished_en) begin
                        r_state   <= S_ISSUE;
                        r_tmo_cnt <= 20'd0;
                        o_cmd     <= w_cmd_idx;
                        o_cmd_arg <= w_cmd_arg;
                        o_cmd_en  <= 1'b1;
                    end
                end
                S_ISSUE: begin
                    r_tmo_cnt <= r_tmo_cnt + 20'd1;
                    if (i_cmd_finished_en) begin
                        r_state  <= S_CHECK;
                        r_rsp    <= i_rsp[31:0];
                        r_err    <= i_error_flag;
                        o_cmd_en <= 1'b0;
                    end else if (r_tmo_cnt == c_TMO_LAST) begin
                        r_state     <= S_FAIL;
                        o_busy      <= 1'b0;
                        o_fail      <= 1'b1;
                        o_fail_code <= c_FAIL_TIMEOUT;
                        o_cmd_en    <= 1'b0;
                    end
                end
                S_CHECK: begin
                    if (r_step != STEP_CMD0 && r_err) begin
                        r_state     <= S_FAIL;
                        o_busy      <= 1'b0;
                        o_fail      <= 1'b1;
                        o_fail_code <= c_FAIL_STACK;
                    end else begin
                        case (r_step)
                            STEP_CMD0: begin
                                r_step  <= STEP_PROBE;
                                r_state <= S_WAIT_RDY;
                            end
                            STEP_PROBE: begin
                                if ((r_rsp[23:0] & OCR_VOLT) == 24'h0) begin
                                    r_state     <= S_FAIL;
                                    o_busy      <= 1'b0;
                                    o_fail      <= 1'b1;
                                    o_fail_code <= c_FAIL_VOLT;
                                end else begin
                                    o_num_funcs   <= r_rsp[30:28];
                                    o_mem_present <= r_rsp[27];
                                    r_step        <= STEP_OCR;
                                    r_state       <= S_WAIT_RDY;
                                end
                            end
                            STEP_OCR: begin
                                if (r_rsp[31]) begin
                                    o_num_funcs   <= r_rsp[30:28];
                                    o_mem_present <= r_rsp[27];
                                    r_step        <= STEP_CMD3;
                                    r_state       <= S_WAIT_RDY;
                                end else if (w_retry_next == c_RETRY_MAX) begin
                                    r_retry     <= w_retry_next;
                                    r_state     <= S_FAIL;
                                    o_busy      <= 1'b0;
                                    o_fail      <= 1'b1;
                                    o_fail_code <= c_FAIL_RETRY;
                                end else begin
                                    r_retry   <= w_retry_next;
                                    r_gap_cnt <= 20'd0;
                                    r_state   <= S_GAP;
                                end
                            end
                            STEP_CMD3: begin
                                o_rca   <= r_rsp[31:16];
                                r_step  <= STEP_CMD7;
                                r_state <= S_WAIT_RDY;
                            end
                            STEP_CMD7: begin
                                r_state <= S_DONE;
                                o_busy  <= 1'b0;
                                o_done  <= 1'b1;
                            end
                            default: begin
                                r_state <= S_WAIT_RDY;
                            end
                        endcase
                    end
                end
                S_GAP: begin
                    r_gap_cnt <= r_gap_cnt + 20'd1;
                    if (r_gap_cnt == c_GAP_LAST) begin
                        r_state <= S_WAIT_RDY;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    o_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sd_init_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_sd_init_sequencer
// Brief    : Directed bench for sd_init_sequencer with a small card responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd_init_sequencer;

    localparam int c_RETRY = 4;
    localparam int c_GAP   = 20;
    localparam int c_TMO   = 50;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         i_start = 1'b0;
    logic         i_card_detect = 1'b1;
    logic         i_sd_ready = 1'b1;
    logic         o_busy, o_done, o_fail, o_mem_present, o_cmd_en, o_rsp_long_flag;
    logic [3:0]   o_fail_code;
    logic [15:0]  o_rca;
    logic [2:0]   o_num_funcs;
    logic [5:0]   o_cmd;
    logic [31:0]  o_cmd_arg;
    logic         i_cmd_finished_en = 1'b0;
    logic [127:0] i_rsp = '0;
    logic         i_error_flag = 1'b0;
    logic [7:0]   i_error = 8'h0;

    int n_vec = 0;
    int n_err = 0;

    sd_init_sequencer #(
        .OCR_VOLT    (24'h300000),
        .RETRY_MAX   (c_RETRY),
        .GAP_CYCLES  (c_GAP),
        .CMD_TIMEOUT (c_TMO)
    ) u_dut (
        .clk               (clk),
        .rst               (rst),
        .i_start           (i_start),
        .i_card_detect     (i_card_detect),
        .i_sd_ready        (i_sd_ready),
        .o_busy            (o_busy),
        .o_done            (o_done),
        .o_fail            (o_fail),
        .o_fail_code       (o_fail_code),
        .o_rca             (o_rca),
        .o_num_funcs       (o_num_funcs),
        .o_mem_present     (o_mem_present),
        .o_cmd_en          (o_cmd_en),
        .o_cmd             (o_cmd),
        .o_cmd_arg         (o_cmd_arg),
        .o_rsp_long_flag   (o_rsp_long_flag),
        .i_cmd_finished_en (i_cmd_finished_en),
        .i_rsp             (i_rsp),
        .i_error_flag      (i_error_flag),
        .i_error           (i_error)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_cmd(output int idle, output bit ok);
        idle = 0;
        ok   = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (o_cmd_en) begin
                ok = 1'b1;
                break;
            end
            idle++;
        end
        if (!ok) chk("wait_cmd_en", 32'(o_cmd_en), 32'd1);
    endtask

    task automatic respond(input logic [31:0] rsp, input bit err);
        @(negedge clk);
        i_rsp             = {96'h0, rsp};
        i_error_flag      = err;
        i_cmd_finished_en = 1'b1;
        @(negedge clk);
        i_cmd_finished_en = 1'b0;
        i_error_flag      = 1'b0;
        chk("cmd_en_drop", 32'(o_cmd_en), 32'd0);
    endtask

    task automatic serve(input logic [5:0] cmd, input logic [31:0] arg,
                         input logic [31:0] rsp, input bit err, output int idle);
        bit ok;
        wait_cmd(idle, ok);
        if (ok) begin
            chk($sformatf("cmd_idx%0d", cmd), 32'(o_cmd), 32'(cmd));
            chk($sformatf("cmd_arg%0d", cmd), o_cmd_arg, arg);
            respond(rsp, err);
        end
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (!o_busy) break;
        end
        chk("idle_reached", 32'(o_busy), 32'd0);
    endtask

    task automatic check_done(input logic [15:0] rca, input logic [2:0] nf, input logic mem);
        chk("done_flag", 32'(o_done), 32'd1);
        chk("fail_flag", 32'(o_fail), 32'd0);
        chk("fail_code", 32'(o_fail_code), 32'd0);
        chk("rca", 32'(o_rca), 32'(rca));
        chk("num_funcs", 32'(o_num_funcs), 32'(nf));
        chk("mem_present", 32'(o_mem_present), 32'(mem));
    endtask

    task automatic check_fail(input logic [3:0] code);
        chk("fail_flag", 32'(o_fail), 32'd1);
        chk("fail_code", 32'(o_fail_code), 32'(code));
        chk("done_flag", 32'(o_done), 32'd0);
    endtask

    // Standard run up to the point where the OCR poll succeeds.
    task automatic run_to_cmd3(input logic [31:0] probe_rsp, input logic [31:0] ocr_rsp);
        int idle;
        do_start();
        serve(6'd0, 32'h0, 32'h0, 1'b0, idle);
        serve(6'd5, 32'h0, probe_rsp, 1'b0, idle);
        serve(6'd5, 32'h00300000, ocr_rsp, 1'b0, idle);
    endtask

    initial begin
        int  idle;
        int  hi;
        bit  ok;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_flags", 32'({o_busy, o_done, o_fail, o_cmd_en, o_mem_present, o_rsp_long_flag}), 32'd0);
        chk("rst_regs", 32'({o_fail_code, o_num_funcs, o_cmd}), 32'd0);
        chk("rst_rca_arg", {o_rca, o_cmd_arg[15:0]} | {16'h0, o_cmd_arg[31:16]}, 32'd0);
        rst = 1'b1;

        // No card at start
        i_card_detect = 1'b0;
        do_start();
        @(negedge clk);
        check_fail(4'd1);
        chk("nocard_busy", 32'(o_busy), 32'd0);
        i_card_detect = 1'b1;

        // Happy path, with the stack briefly not ready
        i_sd_ready = 1'b0;
        do_start();
        repeat (5) @(negedge clk);
        chk("notready_cmd_en", 32'(o_cmd_en), 32'd0);
        chk("notready_busy", 32'(o_busy), 32'd1);
        chk("restart_clears_fail", 32'(o_fail), 32'd0);
        i_sd_ready = 1'b1;
        serve(6'd0, 32'h0, 32'h0, 1'b0, idle);
        serve(6'd5, 32'h0, 32'h10300000, 1'b0, idle);
        serve(6'd5, 32'h00300000, 32'h90300000, 1'b0, idle);
        serve(6'd3, 32'h0, 32'hABCD0000, 1'b0, idle);
        serve(6'd7, 32'hABCD0000, 32'h0, 1'b0, idle);
        wait_idle();
        check_done(16'hABCD, 3'd1, 1'b0);

        // Poll retry: three not-ready polls, then ready; R4 fields re-latched
        do_start();
        serve(6'd0, 32'h0, 32'h0, 1'b0, idle);
        serve(6'd5, 32'h0, 32'h38300000, 1'b0, idle);
        serve(6'd5, 32'h00300000, 32'h08300000, 1'b0, idle);
        for (int p = 0; p < 3; p++) begin
            serve(6'd5, 32'h00300000, (p == 2) ? 32'hC8300000 : 32'h08300000, 1'b0, idle);
            chk($sformatf("gap_ge_%0d_idle_%0d", c_GAP, idle), 32'(idle >= c_GAP), 32'd1);
        end
        serve(6'd3, 32'h0, 32'h12340000, 1'b0, idle);
        serve(6'd7, 32'h12340000, 32'h0, 1'b0, idle);
        wait_idle();
        check_done(16'h1234, 3'd4, 1'b1);

        // Retries exhausted
        do_start();
        serve(6'd0, 32'h0, 32'h0, 1'b0, idle);
        serve(6'd5, 32'h0, 32'h10300000, 1'b0, idle);
        for (int p = 0; p < c_RETRY; p++) begin
            serve(6'd5, 32'h00300000, 32'h00300000, 1'b0, idle);
        end
        wait_idle();
        check_fail(4'd4);
        repeat (3) @(negedge clk);
        chk("exhaust_no_more_cmd", 32'(o_cmd_en), 32'd0);

        // Timeout on CMD3
        run_to_cmd3(32'h10300000, 32'h90300000);
        wait_cmd(idle, ok);
        if (ok) begin
            chk("tmo_cmd_idx", 32'(o_cmd), 32'd3);
            hi = 1;
            for (int i = 0; i < 1000; i++) begin
                @(negedge clk);
                if (!o_cmd_en) break;
                hi++;
            end
            chk("tmo_cmd_en_len", 32'(hi), 32'(c_TMO));
        end
        check_fail(4'd2);
        chk("tmo_busy", 32'(o_busy), 32'd0);

        // Card removed during CMD3 issue, coincident with finished
        run_to_cmd3(32'h10300000, 32'h90300000);
        wait_cmd(idle, ok);
        if (ok) begin
            i_rsp             = {96'h0, 32'h55550000};
            i_cmd_finished_en = 1'b1;
            i_card_detect     = 1'b0;
            @(negedge clk);
            i_cmd_finished_en = 1'b0;
            chk("removed_cmd_en", 32'(o_cmd_en), 32'd0);
            check_fail(4'd6);
            chk("removed_rca", 32'(o_rca), 32'd0);
            i_card_detect = 1'b1;
        end

        // Stack error on the probe
        do_start();
        serve(6'd0, 32'h0, 32'h0, 1'b0, idle);
        serve(6'd5, 32'h0, 32'h10300000, 1'b1, idle);
        wait_idle();
        check_fail(4'd3);

        // Voltage mismatch on the probe
        do_start();
        serve(6'd0, 32'h0, 32'h0, 1'b0, idle);
        serve(6'd5, 32'h0, 32'h10000000, 1'b0, idle);
        wait_idle();
        check_fail(4'd5);

        // Clean restart from FAIL
        run_to_cmd3(32'h10300000, 32'h90300000);
        serve(6'd3, 32'h0, 32'h0BEE0000, 1'b0, idle);
        serve(6'd7, 32'h0BEE0000, 32'h0, 1'b0, idle);
        wait_idle();
        check_done(16'h0BEE, 3'd1, 1'b0);

        // Asynchronous reset in the middle of an OCR poll
        do_start();
        serve(6'd0, 32'h0, 32'h0, 1'b0, idle);
        serve(6'd5, 32'h0, 32'h38300000, 1'b0, idle);
        wait_cmd(idle, ok);
        #2 rst = 1'b0;
        #1;
        chk("arst_cmd_en", 32'(o_cmd_en), 32'd0);
        chk("arst_flags", 32'({o_busy, o_done, o_fail, o_mem_present, o_num_funcs, o_fail_code}), 32'd0);
        chk("arst_cmd_arg", o_cmd_arg, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("arst_stays_idle", 32'({o_busy, o_cmd_en}), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
